// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-return back end (quarters, dimes, nickels).
// Amounts are in nickel units. Each coin is one SELECT cycle, PULSE_CYC
// cycles of solenoid drive and GAP_CYC idle cycles.
// Optional feature macro: CHANGE_DISP_INV_EN. When it is defined, coin
// inventory counters, refill inputs and shortfall reporting are present.
// When it is undefined, supply is unlimited and cnt_*/short are tied to 0.
module change_dispenser #(
  parameter int AMT_W     = 5,
  parameter int INV_W     = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int INIT_NI   = 10,
  parameter int INIT_DI   = 10,
  parameter int INIT_QU   = 10
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amt,
  input  logic             refill_ni,
  input  logic             refill_di,
  input  logic             refill_qu,
  output logic             ej_ni,
  output logic             ej_di,
  output logic             ej_qu,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [INV_W-1:0] cnt_ni,
  output logic [INV_W-1:0] cnt_di,
  output logic [INV_W-1:0] cnt_qu
);

  localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
`ifdef CHANGE_DISP_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_FINISH} state_t;
  typedef enum logic [1:0] {C_NONE, C_NI, C_DI, C_QU} coin_t;

  state_t           state, state_nx;
  coin_t            coin, coin_nx;
  logic [AMT_W-1:0] rem, rem_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic             short_nx;
  logic             dec_ni, dec_di, dec_qu;
  logic             have_ni, have_di, have_qu;

`ifdef CHANGE_DISP_INV_EN
  assign have_ni = (cnt_ni != '0);
  assign have_di = (cnt_di != '0);
  assign have_qu = (cnt_qu != '0);
`else
  assign have_ni = 1'b1;
  assign have_di = 1'b1;
  assign have_qu = 1'b1;
`endif

  // Next-state: greedy selection, pulse/gap timing, remainder bookkeeping.
  always_comb begin
    state_nx = state;
    coin_nx  = coin;
    rem_nx   = rem;
    tmr_nx   = tmr;
    short_nx = short;
    dec_ni   = 1'b0;
    dec_di   = 1'b0;
    dec_qu   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          rem_nx   = amt;
          short_nx = 1'b0;
          state_nx = S_SELECT;
        end
      end
      S_SELECT: begin
        tmr_nx = '0;
        if (rem >= AMT_W'(5) && have_qu) begin
          coin_nx  = C_QU;
          rem_nx   = rem - AMT_W'(5);
          dec_qu   = 1'b1;
          state_nx = S_PULSE;
        end else if (rem >= AMT_W'(2) && have_di) begin
          coin_nx  = C_DI;
          rem_nx   = rem - AMT_W'(2);
          dec_di   = 1'b1;
          state_nx = S_PULSE;
        end else if (rem >= AMT_W'(1) && have_ni) begin
          coin_nx  = C_NI;
          rem_nx   = rem - AMT_W'(1);
          dec_ni   = 1'b1;
          state_nx = S_PULSE;
        end else begin
          coin_nx  = C_NONE;
          short_nx = INV_EN && (rem != '0);
          state_nx = S_FINISH;
        end
      end
      S_PULSE: begin
        if (tmr == TW'(PULSE_CYC - 1)) begin
          tmr_nx   = '0;
          state_nx = S_GAP;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_GAP: begin
        if (tmr == TW'(GAP_CYC - 1)) begin
          tmr_nx   = '0;
          coin_nx  = C_NONE;
          state_nx = S_SELECT;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register; outputs are registered off the next state so they
  // line up with the state they describe and drop at once on reset.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      coin  <= C_NONE;
      rem   <= '0;
      tmr   <= '0;
      short <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ej_ni <= 1'b0;
      ej_di <= 1'b0;
      ej_qu <= 1'b0;
    end else begin
      state <= state_nx;
      coin  <= coin_nx;
      rem   <= rem_nx;
      tmr   <= tmr_nx;
      short <= short_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_FINISH);
      ej_ni <= (state_nx == S_PULSE) && (coin_nx == C_NI);
      ej_di <= (state_nx == S_PULSE) && (coin_nx == C_DI);
      ej_qu <= (state_nx == S_PULSE) && (coin_nx == C_QU);
    end
  end

`ifdef CHANGE_DISP_INV_EN
  // Saturating +1 on refill, -1 on eject; both together cancel out.
  function automatic logic [INV_W-1:0] cnt_upd(input logic [INV_W-1:0] c,
                                               input logic inc, input logic dec);
    logic [INV_W-1:0] r;
    r = c;
    if (inc && !dec && c != '1) r = c + INV_W'(1);
    else if (dec && !inc)       r = c - INV_W'(1);
    return r;
  endfunction

  // Inventory counters, refilled in every state.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt_ni <= INV_W'(INIT_NI);
      cnt_di <= INV_W'(INIT_DI);
      cnt_qu <= INV_W'(INIT_QU);
    end else begin
      cnt_ni <= cnt_upd(cnt_ni, refill_ni, dec_ni);
      cnt_di <= cnt_upd(cnt_di, refill_di, dec_di);
      cnt_qu <= cnt_upd(cnt_qu, refill_qu, dec_qu);
    end
  end
`else
  // Unlimited supply: no counters, refills have nothing to act on.
  assign cnt_ni = '0;
  assign cnt_di = '0;
  assign cnt_qu = '0;
  logic             unused_inv;
  logic [INV_W-1:0] unused_init;
  assign unused_inv  = ^{refill_ni, refill_di, refill_qu, dec_ni, dec_di, dec_qu};
  assign unused_init = INV_W'(INIT_NI) ^ INV_W'(INIT_DI) ^ INV_W'(INIT_QU);
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (default inventory and a
// starved one) checked cycle by cycle against a greedy payout model.
module tb_change_dispenser;
  localparam int P = 2, G = 2, C = P + G + 1;
`ifdef CHANGE_DISP_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req = '0;
  logic [4:0]      amt [2];
  logic [1:0][2:0] rf = '0;   // bit0 nickel, bit1 dime, bit2 quarter
  logic [1:0][2:0] ej;
  logic [1:0]      busy, done, short;
  logic [7:0]      cnt [2][3];

  int errors = 0, checks = 0;
  int inv [2][3];
  int init_v [2][3] = '{'{10, 10, 10}, '{2, 0, 0}};
  int val [3] = '{1, 2, 5};
  bit prev_short [2];

  always #5 CLK = ~CLK;

  change_dispenser dut0 (
    .CLK(CLK), .rst(rst), .req(req[0]), .amt(amt[0]),
    .refill_ni(rf[0][0]), .refill_di(rf[0][1]), .refill_qu(rf[0][2]),
    .ej_ni(ej[0][0]), .ej_di(ej[0][1]), .ej_qu(ej[0][2]),
    .busy(busy[0]), .done(done[0]), .short(short[0]),
    .cnt_ni(cnt[0][0]), .cnt_di(cnt[0][1]), .cnt_qu(cnt[0][2]));

  change_dispenser #(.INIT_NI(2), .INIT_DI(0), .INIT_QU(0)) dut1 (
    .CLK(CLK), .rst(rst), .req(req[1]), .amt(amt[1]),
    .refill_ni(rf[1][0]), .refill_di(rf[1][1]), .refill_qu(rf[1][2]),
    .ej_ni(ej[1][0]), .ej_di(ej[1][1]), .ej_qu(ej[1][2]),
    .busy(busy[1]), .done(done[1]), .short(short[1]),
    .cnt_ni(cnt[1][0]), .cnt_di(cnt[1][1]), .cnt_qu(cnt[1][2]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int sat_add(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      prev_short[s] = 1'b0;
      for (int i = 0; i < 3; i++) inv[s][i] = init_v[s][i];
    end
  endtask

  // One payout on instance s: optional one-cycle refill (type rf_type at
  // cycle rf_cyc) and optional extra req at cycle x_cyc while busy.
  task automatic run_txn(input int s, input int a, input int rf_cyc,
                         input int rf_type, input int x_cyc);
    int coins[$];
    int rm, sc, done_cyc, kk;
    bit rf_pend, sh;
    logic [2:0] e;
    rm = a;
    rf_pend = (rf_type >= 0);
    forever begin
      int pick;
      sc = 1 + coins.size() * C;
      if (rf_pend && rf_cyc < sc) begin
        inv[s][rf_type] = sat_add(inv[s][rf_type]);
        rf_pend = 1'b0;
      end
      pick = -1;
      for (int c = 2; c >= 0; c--)
        if (pick < 0 && rm >= val[c] && (!INV || inv[s][c] > 0)) pick = c;
      if (pick < 0) break;
      if (rf_pend && rf_cyc == sc && rf_type == pick) rf_pend = 1'b0;
      else inv[s][pick] = inv[s][pick] - 1;
      rm = rm - val[pick];
      coins.push_back(pick);
    end
    done_cyc = 2 + coins.size() * C;
    sh = INV && (rm != 0);
    if (rf_pend) begin
      if (rf_cyc <= done_cyc + 1) inv[s][rf_type] = sat_add(inv[s][rf_type]);
      else rf_type = -1;
    end
    if (x_cyc > done_cyc) x_cyc = -1;

    for (int t = 0; t <= done_cyc + 1; t++) begin
      req[s] = (t == 0) || (t == x_cyc);
      amt[s] = (t == 0) ? 5'(a) : 5'd5;
      rf[s]  = (rf_type >= 0 && t == rf_cyc) ? 3'(1 << rf_type) : 3'b000;
      e = 3'b000;
      kk = (t - 2) / C;
      if (t >= 2 && kk < coins.size() && ((t - 2) % C) < P) e = 3'(1 << coins[kk]);
      checks++;
      if (ej[s] !== e) begin
        errors++;
        $display("FAIL ej s=%0d amt=%0d t=%0d got=%b exp=%b", s, a, t, ej[s], e);
      end
      checks++;
      if (busy[s] !== (t >= 1 && t <= done_cyc)) begin
        errors++;
        $display("FAIL busy s=%0d amt=%0d t=%0d got=%b", s, a, t, busy[s]);
      end
      checks++;
      if (done[s] !== (t == done_cyc)) begin
        errors++;
        $display("FAIL done s=%0d amt=%0d t=%0d got=%b exp_cyc=%0d", s, a, t, done[s], done_cyc);
      end
      checks++;
      if (short[s] !== ((t == 0) ? prev_short[s] : (t >= done_cyc) ? sh : 1'b0)) begin
        errors++;
        $display("FAIL short s=%0d amt=%0d t=%0d got=%b", s, a, t, short[s]);
      end
      tick();
    end
    req[s] = 1'b0;
    rf[s]  = 3'b000;
    prev_short[s] = sh;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[s][i] !== 8'(INV ? inv[s][i] : 0)) begin
        errors++;
        $display("FAIL cnt s=%0d amt=%0d coin=%0d got=%0d exp=%0d", s, a, i, cnt[s][i], INV ? inv[s][i] : 0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    amt[0] = '0;
    amt[1] = '0;
    model_reset();
    #12;
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({ej[s], busy[s], done[s], short[s]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_out s=%0d got=%b exp=0", s, {ej[s], busy[s], done[s], short[s]});
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[s][i] !== 8'(INV ? init_v[s][i] : 0)) begin
          errors++;
          $display("FAIL reset_cnt s=%0d coin=%0d got=%0d", s, i, cnt[s][i]);
        end
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_payout();
    run_txn(0, 8, -1, -1, -1);
  endtask

  task automatic test_zero_amount();
    run_txn(0, 0, -1, -1, -1);
  endtask

  task automatic test_busy_refill();
    run_txn(0, 8, 1, 2, 4);    // refill_qu with the quarter decrement, req at 4
  endtask

  task automatic test_reset_mid();
    req[0] = 1'b1;
    amt[0] = 5'd8;
    tick();
    req[0] = 1'b0;
    tick();                      // cycle 2: quarter pulse
    checks++;
    if (ej[0] !== 3'b100) begin
      errors++;
      $display("FAIL mid_pulse got=%b exp=100", ej[0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ej[0], busy[0], done[0]} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=0", {ej[0], busy[0], done[0]});
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[0][i] !== 8'(INV ? init_v[0][i] : 0)) begin
        errors++;
        $display("FAIL reload_cnt coin=%0d got=%0d", i, cnt[0][i]);
      end
    end
    #2 rst = 1'b1;
    tick();
    run_txn(0, 8, -1, -1, -1);
  endtask

  task automatic test_saturation();
    rf[0] = 3'b001;
    for (int i = 0; i < 250; i++) begin
      tick();
      inv[0][0] = sat_add(inv[0][0]);
    end
    rf[0] = 3'b000;
    checks++;
    if (cnt[0][0] !== 8'(INV ? 255 : 0)) begin
      errors++;
      $display("FAIL saturate got=%0d exp=%0d", cnt[0][0], INV ? 255 : 0);
    end
    run_txn(0, 1, 1, 0, -1);   // nickel decrement and refill together at 255
  endtask

  task automatic test_shortfall();
    run_txn(1, 3, -1, -1, -1);
    run_txn(1, 5, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int s, n;
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, 2);
        rf[s] = 3'(1 << n);
        tick();
        rf[s] = 3'b000;
        inv[s][n] = sat_add(inv[s][n]);
      end
      run_txn(s, $urandom_range(0, 31), $urandom_range(0, 40),
              $urandom_range(0, 3) - 1, $urandom_range(1, 40));
    end
  endtask

  initial begin
    test_reset();
    test_full_payout();
    test_zero_amount();
    test_reset_mid();
    test_busy_refill();
    test_saturation();
    test_shortfall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
